// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling at a fixed
// clocks-per-bit divisor, one-cycle valid / frame_err strobes.
module uart_rx #(
  parameter int divisor = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxi,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // Output protocol: valid and frame_err are single-cycle strobes with no
  // ready/backpressure; the consumer must take data while valid is high (or
  // before the next valid). data holds the last good byte between strobes.

  localparam int cw = $clog2(divisor);
  localparam logic [cw-1:0] cnt_half = cw'(divisor / 2 - 1);
  localparam logic [cw-1:0] cnt_full = cw'(divisor - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic          sync1, sync2;
  logic          rxs;
  logic [2:0]    state;
  logic [cw-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          sample;

  // Synchronizer resets high so a reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxi;
      sync2 <= sync1;
    end
  end

  assign rxs       = sync2;
  assign sample    = (cnt == '0);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      if (state != IDLE) begin
        if (sample) cnt <= cnt_full;
        else        cnt <= cnt - cw'(1);
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= cnt_half;
          end
        end
        START: begin
          if (sample) begin
            if (!rxs) begin
              state <= DATA;
              idx   <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample) begin
            // LSB arrives first, so shifting in from the top leaves bit 0 at shreg[0].
            shreg <= {rxs, shreg[7:1]};
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end
        end
        STOP: begin
          if (sample) begin
            if (rxs) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          // Wait out a held-low line so it yields one frame_err, not a stream of frames.
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the downstream counterpart of uart_tx.
- Samples a UART line (8N1, LSB first, idle high) at a fixed clocks-per-bit divisor.
- Presents each received byte with a one-cycle valid strobe.
- Sits between the external RX pin (or a uart_tx txo in loopback) and the display-controller command logic.

Parameters:
- divisor, 32, clock cycles per bit; even, minimum 4; must match the transmitter's divisor.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rxi  input  1  serial line, asynchronous to clk, idles high.
- data  output  8  last received byte; holds until the next valid byte.
- valid  output  1  one-cycle strobe, asserted when data updates with a good frame.
- frame_err  output  1  one-cycle strobe, asserted when the stop bit samples low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values:
  - data=8'h00, valid=0, frame_err=0, busy=0.
  - state=IDLE.
  - Both synchronizer flops = 1, so reset never produces a false start.
- Synchronizer: rxi passes through 2 flops to give rxs. All decisions use rxs only.
- Counter: cnt, width clog2(divisor).
  - In any non-IDLE state: if cnt!=0, cnt decrements each cycle.
  - When cnt==0 a "sample" occurs and cnt reloads divisor-1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rxs==0, go to START with cnt=divisor/2-1.
  - START, on sample:
    - rxs==0: go to DATA, bit index=0.
    - rxs==1: false start (glitch shorter than half a bit); return to IDLE with no strobe.
  - DATA, on sample:
    - Shift rxs into bit[index] (LSB first).
    - After the 8th bit, go to STOP.
  - STOP, on sample:
    - rxs==1: data<=shift register, valid=1 for one cycle, go to IDLE.
    - rxs==0: frame_err=1 for one cycle, data unchanged, go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. A held-low line therefore yields exactly one frame_err, not repeated frames.
- Timing:
  - Let k0 be the first posedge at which the first synchronizer flop captures rxi=0.
  - The START transition occurs at k0+2.
  - The start bit is sampled at k0+2+divisor/2.
  - Data bit n (0..7) is sampled at k0+2+divisor/2+(n+1)*divisor.
  - The stop bit is sampled at k0+2+divisor/2+9*divisor; valid or frame_err is high for the cycle following that edge.
  - For divisor=32: valid at k0+306.
- Back-to-back frames:
  - The FSM returns to IDLE mid-stop-bit and can detect the next start edge immediately.
  - This tolerates a transmitter that inserts only one extra clock between frames.
- No backpressure: valid is a strobe, and the consumer must capture data in that cycle or before the next valid.
- Strobe exclusivity: valid and frame_err are never high in the same cycle.
- busy: asserted from the START transition until the return to IDLE, including BREAK.
- Reset mid-frame: returns immediately to IDLE with reset values. The partial byte is discarded and no strobe is produced.

Test Plan:
- Idle/reset: hold rxi=1 and pulse rst for 10 cycles -> valid, frame_err and busy stay 0; data=8'h00 for 1000 cycles.
- Loopback with uart_tx (divisor=32): send bytes 0..255 back-to-back -> exactly 256 valid pulses, data==j on the j-th pulse, frame_err never set.
- Exact latency: drive 8'hA5 by hand with 32-cycle bits, rxi falling just before posedge k0 -> valid high only in the cycle after edge k0+306, data=8'hA5, busy low at k0+307.
- Glitch: drive rxi low for 10 cycles, then high -> busy pulses, but no valid or frame_err; the next clean 8'h3C frame is received correctly.
- Framing error: send 8'hFF with a low stop bit and the line low for 200 cycles, then high -> one frame_err pulse, data keeps its previous value, busy stays high until the line is high, then a following 8'h5A frame gives valid with data=8'h5A.
- Reset mid-frame: assert rst during data bit 4 of 8'h81, then release and send 8'h42 -> no strobe for the aborted frame, data=8'h42 on the next valid.
